// File: rtl/fp32_stream_min_if.sv
// Stream bundle for fp32_stream_min: element input channel and result output channel.
interface fp32_stream_min_if #(parameter int IDX_W = 16);
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_min;
  logic [IDX_W-1:0] m_idx;
  logic             m_all_nan;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_min, m_idx, m_all_nan
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_min, m_idx, m_all_nan
  );
endinterface

// File: rtl/fp32_stream_min.sv
// Streaming fp32 arg-min reducer: one result beat (min, index, all-NaN) per frame.
// Optional macro FP32_MIN_ARGIDX_EN enables the element index tracking; otherwise m_idx is 0.
//
// state | meaning
// IDLE  | waiting for first element of a frame
// ACCUM | folding further elements into the running minimum
// HOLD  | result presented, waiting for m_ready
module fp32_stream_min #(
  parameter int IDX_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  fp32_stream_min_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] acc, acc_n;
  logic        all_nan, all_nan_n;
  logic        armed;
  logic        accept;

`ifdef FP32_MIN_ARGIDX_EN
  logic [IDX_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] acc_idx, acc_idx_n;
`endif

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // True when x strictly beats a; a NaN accumulator loses to any number.
  function automatic logic less(input logic [31:0] x, input logic [31:0] a);
    if (is_nan(a))      return !is_nan(x);
    if (is_nan(x))      return 1'b0;
    if (x[31] != a[31]) return x[31];
    if (!x[31])         return x < a;
    return x > a;
  endfunction

  // armed keeps s_ready low until the first edge after reset release.
  assign accept        = bus.s_valid && bus.s_ready;
  assign bus.s_ready   = armed && (state != HOLD);
  assign bus.m_valid   = (state == HOLD);
  assign bus.m_min     = acc;
  assign bus.m_all_nan = all_nan;
`ifdef FP32_MIN_ARGIDX_EN
  assign bus.m_idx     = acc_idx;
`else
  assign bus.m_idx     = {IDX_W{1'b0}};
`endif

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    all_nan_n = all_nan;
`ifdef FP32_MIN_ARGIDX_EN
    cnt_n     = cnt;
    acc_idx_n = acc_idx;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          acc_n     = bus.s_data;
          all_nan_n = is_nan(bus.s_data);
`ifdef FP32_MIN_ARGIDX_EN
          cnt_n     = IDX_W'(1);
          acc_idx_n = '0;
`endif
          state_n   = bus.s_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (less(bus.s_data, acc)) begin
            acc_n     = bus.s_data;
`ifdef FP32_MIN_ARGIDX_EN
            acc_idx_n = cnt;
`endif
          end
          all_nan_n = all_nan & is_nan(bus.s_data);
`ifdef FP32_MIN_ARGIDX_EN
          cnt_n     = cnt + IDX_W'(1);
`endif
          if (bus.s_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.m_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      all_nan <= 1'b0;
      armed   <= 1'b0;
`ifdef FP32_MIN_ARGIDX_EN
      cnt     <= '0;
      acc_idx <= '0;
`endif
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      all_nan <= all_nan_n;
      armed   <= 1'b1;
`ifdef FP32_MIN_ARGIDX_EN
      cnt     <= cnt_n;
      acc_idx <= acc_idx_n;
`endif
    end
  end

endmodule

// File: tb/tb_fp32_stream_min.sv
// Directed bench for fp32_stream_min: frame vector table plus backpressure, reset and back-to-back sequences.
module tb_fp32_stream_min;
  localparam int IDX_W = 16;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  fp32_stream_min_if #(.IDX_W(IDX_W)) bus ();

  fp32_stream_min #(.IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0][31:0] d;
    int               len;
    logic [31:0]      mn;
    logic [15:0]      idx;
    logic             an;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input int len, input logic [31:0] mn,
                              input logic [15:0] idx, input logic an);
    vec_t v;
    v.d[0] = e0; v.d[1] = e1; v.d[2] = e2; v.d[3] = e3;
    v.len = len; v.mn = mn; v.idx = idx; v.an = an;
    return v;
  endfunction

  function automatic logic [15:0] exp_idx(input logic [15:0] i);
`ifdef FP32_MIN_ARGIDX_EN
    return i;
`else
    return 16'd0 & i;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Present one element at a negedge and return at the negedge after it is accepted.
  task automatic send_beat(input logic [31:0] data, input logic last);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no s_ready expected s_ready within 50 cycles");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    for (int i = 0; i < v.len; i++) send_beat(v.d[i], (i == v.len - 1));
  endtask

  task automatic check_result(input string tag, input logic [31:0] mn,
                              input logic [15:0] idx, input logic an);
    check({tag, "_valid"}, {31'd0, bus.m_valid}, 32'd1);
    check({tag, "_min"}, bus.m_min, mn);
    check({tag, "_idx"}, {16'd0, bus.m_idx}, {16'd0, exp_idx(idx)});
    check({tag, "_all_nan"}, {31'd0, bus.m_all_nan}, {31'd0, an});
  endtask

  task automatic take_result(input string tag);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check({tag, "_drop_valid"}, {31'd0, bus.m_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, bus.s_ready}, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, bus.m_valid}, 32'd0);
    check({tag, "_m_min"}, bus.m_min, 32'd0);
    check({tag, "_m_idx"}, {16'd0, bus.m_idx}, 32'd0);
    check({tag, "_m_all_nan"}, {31'd0, bus.m_all_nan}, 32'd0);
  endtask

  initial begin
    vecs[0] = mk(32'h40400000, 32'hBFC00000, 32'h40000000, 32'hBFC00000, 4, 32'hBFC00000, 16'd1, 1'b0);
    vecs[1] = mk(32'h00000000, 32'h80000000, 32'h0, 32'h0, 2, 32'h80000000, 16'd1, 1'b0);
    vecs[2] = mk(32'h7FC00000, 32'h7F800000, 32'h7F800001, 32'h0, 3, 32'h7F800000, 16'd1, 1'b0);
    vecs[3] = mk(32'h7FC00000, 32'hFFC00001, 32'h0, 32'h0, 2, 32'h7FC00000, 16'd0, 1'b1);
    vecs[4] = mk(32'hBF800000, 32'hC0400000, 32'hC0000000, 32'h0, 3, 32'hC0400000, 16'd1, 1'b0);
    vecs[5] = mk(32'h40000000, 32'h3F800000, 32'h3F800000, 32'h0, 3, 32'h3F800000, 16'd1, 1'b0);
    vecs[6] = mk(32'h3F800000, 32'h0, 32'h0, 32'h0, 1, 32'h3F800000, 16'd0, 1'b0);
    vecs[7] = mk(32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000001, 4, 32'hFF800000, 16'd1, 1'b0);

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, bus.s_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i]);
      check_result($sformatf("vec%0d", i), vecs[i].mn, vecs[i].idx, vecs[i].an);
      take_result($sformatf("vec%0d", i));
    end

    // Backpressure with a new element waiting upstream during HOLD.
    send_beat(32'h40400000, 1'b0);
    send_beat(32'hBFC00000, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hFF800000;
    bus.s_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_result($sformatf("bp%0d", c), 32'hBFC00000, 16'd1, 1'b0);
      check($sformatf("bp%0d_s_ready", c), {31'd0, bus.s_ready}, 32'd0);
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("bp_drop_valid", {31'd0, bus.m_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, bus.s_ready}, 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check_result("bp_next", 32'hFF800000, 16'd0, 1'b0);
    take_result("bp_next");

    // Reset in the middle of a frame.
    send_beat(32'h40000000, 1'b0);
    send_beat(32'h3F800000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, bus.s_ready}, 32'd1);
    send_beat(32'hFF800000, 1'b1);
    check_result("midrst_next", 32'hFF800000, 16'd0, 1'b0);
    take_result("midrst_next");

    // Back-to-back single-element frames with m_ready held high.
    bus.m_ready = 1'b1;
    send_beat(32'h3F800000, 1'b1);
    check_result("b2b_a", 32'h3F800000, 16'd0, 1'b0);
    send_beat(32'hC0000000, 1'b1);
    check_result("b2b_b", 32'hC0000000, 16'd0, 1'b0);
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("b2b_drop_valid", {31'd0, bus.m_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
